// File: rtl/audio_sample_mux_if.sv
// Sample request/response bundle between channel generators, the sample mux and the codec side.
`timescale 1ns/1ps
interface audio_sample_mux_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 24
);
  logic                                 new_sample;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] channel_in;
  logic [SAMPLE_WIDTH-1:0]              hphone_l;
  logic [SAMPLE_WIDTH-1:0]              hphone_r;
  logic                                 hphone_valid;

  modport master (
    output new_sample, channel_in,
    input  hphone_l, hphone_r, hphone_valid
  );

  modport slave (
    input  new_sample, channel_in,
    output hphone_l, hphone_r, hphone_valid
  );
endinterface

// File: rtl/audio_sample_mux.sv
// Per codec request, builds one headphone L/R pair from NUM_CHANNELS samples:
// solo, routed mix with volume and saturation, sawtooth test tone, or mute.
//
// state | meaning
// IDLE  | waiting for new_sample; request fields are snapshotted on acceptance
// ACCUM | one channel per cycle into the left/right accumulators
// SCALE | volume, saturation or tone selection; outputs load at the end of this cycle
`timescale 1ns/1ps
module audio_sample_mux #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SAW_BITS     = 6,
  parameter int VOL_BITS     = 3
) (
  input  logic                          system_clock,
  input  logic                          reset,
  audio_sample_mux_if.slave             bus,
  input  logic [1:0]                    mode,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] solo_sel,
  input  logic [NUM_CHANNELS-1:0]       left_enable,
  input  logic [NUM_CHANNELS-1:0]       right_enable,
  input  logic [VOL_BITS-1:0]           left_vol,
  input  logic [VOL_BITS-1:0]           right_vol,
  output logic                          busy,
  output logic                          overrun
);
  localparam int SEL_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int ACC_W  = SAMPLE_WIDTH + $clog2(NUM_CHANNELS) + 1;
  localparam int PROD_W = ACC_W + VOL_BITS + 1;
  localparam logic [1:0] MODE_SOLO = 2'b00;
  localparam logic [1:0] MODE_MIX  = 2'b01;
  localparam logic [1:0] MODE_SAW  = 2'b10;
  localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t state_q, state_d;

  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] chan_q;
  logic [1:0]                           mode_q;
  logic [SEL_W-1:0]                     sel_q;
  logic [NUM_CHANNELS-1:0]              len_q, ren_q;
  logic [VOL_BITS-1:0]                  lvol_q, rvol_q;
  logic [SEL_W-1:0]                     idx_q;
  logic [ACC_W-1:0]                     acc_l_q, acc_r_q;
  logic [SAW_BITS-1:0]                  saw_q;

  logic accept, drop, acc_step, scale_step, last_ch;
  logic add_l, add_r;
  logic [SAMPLE_WIDTH-1:0] ch_cur;
  logic [SAMPLE_WIDTH-1:0] out_l, out_r, saw_word;
  logic [VOL_BITS:0]       gain_l, gain_r;
  logic [PROD_W-1:0]       prod_l, prod_r, shf_l, shf_r;
  logic                    sel_ok;

  assign last_ch = (idx_q == SEL_W'(NUM_CHANNELS - 1));
  assign ch_cur  = chan_q[int'(idx_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH];

  always_ff @(posedge system_clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    drop       = 1'b0;
    acc_step   = 1'b0;
    scale_step = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.new_sample) begin
          accept  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        busy     = 1'b1;
        acc_step = 1'b1;
        drop     = bus.new_sample;
        if (last_ch) state_d = SCALE;
      end
      SCALE: begin
        busy       = 1'b1;
        scale_step = 1'b1;
        drop       = bus.new_sample;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Which accumulators take the channel currently indexed.
  always_comb begin
    add_l = 1'b0;
    add_r = 1'b0;
    case (mode_q)
      MODE_MIX: begin
        add_l = len_q[idx_q];
        add_r = ren_q[idx_q];
      end
      MODE_SOLO: begin
        add_l = (idx_q == sel_q);
        add_r = (idx_q == sel_q);
      end
      default: ;
    endcase
  end

  always_comb begin
    gain_l   = {1'b0, lvol_q} + (VOL_BITS+1)'(1);
    gain_r   = {1'b0, rvol_q} + (VOL_BITS+1)'(1);
    prod_l   = PROD_W'(acc_l_q) * PROD_W'(gain_l);
    prod_r   = PROD_W'(acc_r_q) * PROD_W'(gain_r);
    shf_l    = prod_l >> VOL_BITS;
    shf_r    = prod_r >> VOL_BITS;
    sel_ok   = (int'(sel_q) < NUM_CHANNELS);
    saw_word = SAMPLE_WIDTH'(saw_q) << (SAMPLE_WIDTH - SAW_BITS);
    out_l    = '0;
    out_r    = '0;
    case (mode_q)
      MODE_MIX: begin
        out_l = (shf_l > PROD_W'(SAMPLE_MAX)) ? SAMPLE_MAX : shf_l[SAMPLE_WIDTH-1:0];
        out_r = (shf_r > PROD_W'(SAMPLE_MAX)) ? SAMPLE_MAX : shf_r[SAMPLE_WIDTH-1:0];
      end
      MODE_SOLO: begin
        if (sel_ok) begin
          out_l = acc_l_q[SAMPLE_WIDTH-1:0];
          out_r = acc_r_q[SAMPLE_WIDTH-1:0];
        end
      end
      MODE_SAW: begin
        out_l = saw_word;
        out_r = saw_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      chan_q           <= '0;
      mode_q           <= '0;
      sel_q            <= '0;
      len_q            <= '0;
      ren_q            <= '0;
      lvol_q           <= '0;
      rvol_q           <= '0;
      idx_q            <= '0;
      acc_l_q          <= '0;
      acc_r_q          <= '0;
      saw_q            <= '0;
      overrun          <= 1'b0;
      bus.hphone_l     <= '0;
      bus.hphone_r     <= '0;
      bus.hphone_valid <= 1'b0;
    end else begin
      if (accept) begin
        chan_q  <= bus.channel_in;
        mode_q  <= mode;
        sel_q   <= solo_sel;
        len_q   <= left_enable;
        ren_q   <= right_enable;
        lvol_q  <= left_vol;
        rvol_q  <= right_vol;
        idx_q   <= '0;
        acc_l_q <= '0;
        acc_r_q <= '0;
      end
      if (acc_step) begin
        if (add_l) acc_l_q <= acc_l_q + ACC_W'(ch_cur);
        if (add_r) acc_r_q <= acc_r_q + ACC_W'(ch_cur);
        idx_q <= idx_q + SEL_W'(1);
      end
      // The tone only advances on its own requests, so muting does not skip steps.
      if (scale_step && (mode_q == MODE_SAW)) saw_q <= saw_q + SAW_BITS'(1);
      if (scale_step) begin
        bus.hphone_l <= out_l;
        bus.hphone_r <= out_r;
      end
      bus.hphone_valid <= scale_step;
      if (drop) overrun <= 1'b1;
    end
  end
endmodule
